mac_accum_block_0: RTL and testbench
====================================

// Module: mac_accum_block_0
// PURPOSE
//  Accumulation stage directly downstream of mac_mult_block_0. Consumes its combined
//  product C as a stream of beats and sums each first..last group into a wide accumulator
//  (one dot product). Emits the sum, its term count and an overflow flag through a
//  valid/ready output register.
// PARAMETERS
//  MIN_W   `MAC_MIN_WIDTH   lane width (8 in bench)
//  MULT_W  `MAC_MULT_WIDTH  single-lane product width (16)
//  INT_W   `MAC_INT_WIDTH   product input width (40 = MULT_W + 3*MIN_W)
//  ACC_W   `MAC_ACC_WIDTH   accumulator/result width, >= INT_W (48)
//  CNT_W   `MAC_CNT_WIDTH   term counter width (8)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active-high
//  en         in   1       stage enable; 0 freezes all state
//  cfg        in   MAC_CONF_WIDTH  `MAC_SINGLE/`MAC_DUAL/`MAC_QUAD; only [1:0] is decoded
//  in_valid   in   1       product beat valid
//  in_ready   out  1       beat accepted when in_valid & in_ready
//  in_data    in   INT_W   unsigned product from multiplier stage
//  in_first   in   1       beat opens a new group
//  in_last    in   1       beat closes the group
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_data   out  ACC_W   group sum (unsigned, modulo 2^ACC_W)
//  out_count  out  CNT_W   terms in group, saturating at 2^CNT_W-1
//  out_ovf    out  1       a carry out of ACC_W occurred within this group
//  proto_err  out  1       sticky: in_first seen while a group was open; cleared only by rst
// BEHAVIOUR
//  - rst (sync): out_valid, out_data, out_count, out_ovf and proto_err = 0. FSM -> IDLE.
//    Stage-1 register is invalidated. Any partial sum is discarded. Applies mid-group too.
//  - adv = en & ~(out_valid & ~out_ready); in_ready = adv (combinational, no in_valid path).
//    All state (stage-1 register, accumulator, FSM, output register) updates only when adv.
//  - Stage 1 (S1): on accept, register masked data, first, last and valid. Otherwise S1
//    valid clears when adv. Mask uses cfg latched on the group's first beat (cfg_q):
//    SINGLE keeps low MULT_W bits; DUAL keeps low MULT_W+MIN_W; QUAD keeps all INT_W.
//    Reserved cfg forces the data to 0. cfg changes mid-group are ignored.
//  - Stage 2 (accumulate), when S1 valid & adv:
//      acc <= (start ? 0 : acc) + zero-extended S1 data; cnt <= start ? 1 : sat(cnt+1);
//      ovf <= (start ? 0 : ovf) | carry-out.
//    start = S1.first | (state == IDLE). A missing first in IDLE is treated as an implicit
//    start and is not an error.
//  - FSM: IDLE --start & ~last--> ACC; ACC --last--> IDLE; in ACC, first restarts the sum
//    and sets proto_err. A first & last beat is a one-term group: IDLE->IDLE with a result.
//  - Output: when an S1 beat with last is accumulated, the output register loads the final
//    acc/cnt/ovf and out_valid = 1. Latency: accept at edge k -> out_valid high after
//    edge k+2.
//  - While out_valid & ~out_ready: out_* are held stable; in_ready = 0; the pipeline is
//    frozen. out_valid & out_ready with adv: out_valid clears, or it reloads in the same
//    cycle if another last completes then (back-to-back results, no bubble).
//  - en = 0: no accept (in_ready = 0); out_valid is held; out_ready is ignored.
//  - Full throughput: one beat per cycle when out_ready stays high.
// STRUCTURE
//  - Add MAC_ACC_WIDTH, MAC_CNT_WIDTH and the FSM state encodings (ACC_IDLE, ACC_RUN) to
//    mac_const.vh next to the existing MAC_SINGLE/DUAL/QUAD codes.
//  - One sub-module: mac_accum_ctrl (FSM, cfg_q latch, term counter, proto_err). The
//    datapath, mask and output register stay in the top module.
// TESTING (bench: MIN_W=8, MULT_W=16, INT_W=40, ACC_W=48, CNT_W=8)
//  1 SINGLE: beats 3(first), 5, 7(last) with out_ready=1 -> out_data=15 and out_count=3,
//    out_valid two cycles after the last accept; out_ovf=0.
//  2 Mask/cfg: DUAL; beat 0x12_3456_789A first&last -> out_data=0x56789A. Then switch cfg to
//    QUAD mid-group; the group still uses DUAL masking.
//  3 Backpressure: out_ready=0 with two back-to-back one-term groups (10, 20) -> first
//    result held, in_ready=0. Raise out_ready -> 10 then 20 on consecutive cycles.
//  4 Overflow/saturation: 300 QUAD beats of 0xFF_FFFF_FFFF -> out_ovf=1, out_count=255,
//    out_data = (300*(2^40-1)) mod 2^48.
//  5 Protocol: first, 4, then first 9 (last) -> out_data=9, proto_err=1. A beat without first
//    in IDLE starts a group silently.
//  6 Reset mid-group and with out_valid pending -> all outputs 0 next cycle; a new group
//    after reset sums from 0.

Source files
------------

// File: rtl/mac_accum_block_0_pkg.sv
// Shared constants for the MAC accumulation stage: widths, lane-mode codes, FSM encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mac_accum_block_0_pkg;

  localparam int MAC_MIN_WIDTH  = 8;
  localparam int MAC_MULT_WIDTH = 16;
  localparam int MAC_INT_WIDTH  = 40;
  localparam int MAC_ACC_WIDTH  = 48;
  localparam int MAC_CNT_WIDTH  = 8;
  localparam int MAC_CONF_WIDTH = 2;

  // Lane-mode codes shared with the multiplier stage; 2'b11 is reserved.
  localparam logic [1:0] MAC_SINGLE = 2'd0;
  localparam logic [1:0] MAC_DUAL   = 2'd1;
  localparam logic [1:0] MAC_QUAD   = 2'd2;

  // Accumulator FSM encodings.
  localparam logic [0:0] ACC_IDLE = 1'b0;
  localparam logic [0:0] ACC_RUN  = 1'b1;

endpackage

// File: rtl/mac_accum_block_0_ctrl.sv
// Control for the accumulator: group FSM, per-group cfg latch, term counter, sticky proto_err.
// Latency: cfg_sel is combinational on the input beat; state/counter update with the accumulate step.
// Backpressure: every register holds unless adv is high.
module mac_accum_block_0_ctrl
  import mac_accum_block_0_pkg::*;
#(
  parameter int CNT_W = MAC_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             accept,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [1:0]       cfg,
  input  logic             s1_vld,
  input  logic             s1_first,
  input  logic             s1_last,
  output logic [1:0]       cfg_sel,
  output logic             start,
  output logic [CNT_W-1:0] cnt,
  output logic             proto_err
);

  // Input-side view of group framing: tracks whether the beat being accepted now
  // belongs to an already-open group, so the mask can use the group's latched cfg.
  logic       in_open;
  logic [1:0] cfg_q;
  logic [0:0] state;
  logic       opens_group;
  logic       step;

  assign opens_group = in_first | ~in_open;
  assign cfg_sel     = opens_group ? cfg : cfg_q;
  assign start       = s1_first | (state == ACC_IDLE);
  assign step        = s1_vld & adv;

  // Latch cfg on the beat that opens a group; later cfg changes in the group are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_open <= 1'b0;
      cfg_q   <= MAC_SINGLE;
    end else if (accept) begin
      in_open <= ~in_last;
      if (opens_group) begin
        cfg_q <= cfg;
      end
    end
  end

  // Group FSM, saturating term counter and sticky first-inside-group error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC_IDLE;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else if (step) begin
      state <= s1_last ? ACC_IDLE : ACC_RUN;
      if (start) begin
        cnt <= CNT_W'(1);
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (s1_first && (state == ACC_RUN)) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_accum_block_0.sv
// Sums first..last groups of multiplier products into a wide accumulator and emits sum/count/ovf.
// Latency: beat accepted at edge k, out_valid high after edge k+2; one beat per cycle sustained.
// Backpressure: out_valid & ~out_ready (or en=0) freezes the whole pipeline and drops in_ready.
module mac_accum_block_0
  import mac_accum_block_0_pkg::*;
#(
  parameter int MIN_W  = MAC_MIN_WIDTH,
  parameter int MULT_W = MAC_MULT_WIDTH,
  parameter int INT_W  = MAC_INT_WIDTH,
  parameter int ACC_W  = MAC_ACC_WIDTH,
  parameter int CNT_W  = MAC_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INT_W-1:0]          in_data,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_ovf,
  output logic                      proto_err
);

  logic             adv;
  logic             accept;
  logic [1:0]       cfg_sel;
  logic [INT_W-1:0] mask_dat;

  logic             s1_vld;
  logic [INT_W-1:0] s1_dat;
  logic             s1_first;
  logic             s1_last;

  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum;
  logic             ovf;
  logic             done;

  // Only a result stuck at the output (or en low) stalls; no dependence on in_valid.
  assign adv      = en & ~(out_valid & ~out_ready);
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  mac_accum_block_0_ctrl #(
    .CNT_W(CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .accept   (accept),
    .in_first (in_first),
    .in_last  (in_last),
    .cfg      (cfg[1:0]),
    .s1_vld   (s1_vld),
    .s1_first (s1_first),
    .s1_last  (s1_last),
    .cfg_sel  (cfg_sel),
    .start    (start),
    .cnt      (cnt),
    .proto_err(proto_err)
  );

  // Keep only the product bits the lane mode can produce; reserved mode yields zero.
  always_comb begin
    mask_dat = '0;
    case (cfg_sel)
      MAC_SINGLE: mask_dat[MULT_W-1:0]       = in_data[MULT_W-1:0];
      MAC_DUAL:   mask_dat[MULT_W+MIN_W-1:0] = in_data[MULT_W+MIN_W-1:0];
      MAC_QUAD:   mask_dat                   = in_data;
      default:    mask_dat                   = '0;
    endcase
  end

  // Stage 1: register the masked beat and its framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_dat   <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_vld <= in_valid;
      if (accept) begin
        s1_dat   <= mask_dat;
        s1_first <= in_first;
        s1_last  <= in_last;
      end
    end
  end

  // Extra top bit of the sum captures the carry out of the accumulator.
  always_comb begin
    acc_base = start ? '0 : acc;
    sum      = {1'b0, acc_base} + (ACC_W + 1)'(s1_dat);
  end

  // Stage 2: accumulate; done marks that acc/cnt/ovf hold a finished group.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else if (adv) begin
      done <= s1_vld & s1_last;
      if (s1_vld) begin
        acc <= sum[ACC_W-1:0];
        ovf <= (start ? 1'b0 : ovf) | sum[ACC_W];
      end
    end
  end

  // Output register: reloads on a finished group, otherwise drains once accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= done;
      if (done) begin
        out_data  <= acc;
        out_count <= cnt;
        out_ovf   <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_mac_accum_block_0.sv
module tb_mac_accum_block_0;
  import mac_accum_block_0_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  cfg;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_data;
  logic        in_first;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [7:0]  out_count;
  logic        out_ovf;
  logic        proto_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mac_accum_block_0 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg      (cfg),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_ovf  (out_ovf),
    .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic beat(input logic [39:0] d, input logic f, input logic l);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) chk("beat_accept_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cfg = MAC_SINGLE;
    in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // 1: SINGLE 3+5+7, latency two edges after the last accept
    beat(40'd3, 1'b1, 1'b0);
    beat(40'd5, 1'b0, 1'b0);
    beat(40'd7, 1'b0, 1'b1);
    chk("t1_valid_k", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid_k1", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid_k2", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'd15);
    chk("t1_count", 64'(out_count), 64'd3);
    chk("t1_ovf", 64'(out_ovf), 64'd0);
    tick();
    chk("t1_drain", 64'(out_valid), 64'd0);

    // 2: DUAL mask, and cfg change mid-group ignored
    cfg = MAC_DUAL;
    beat(40'h12_3456_789A, 1'b1, 1'b1);
    wait_out("t2a");
    chk("t2_dual_data", 64'(out_data), 64'h56789A);
    tick();
    beat(40'h12_3456_789A, 1'b1, 1'b0);
    cfg = MAC_QUAD;
    beat(40'h01_0000_0001, 1'b0, 1'b1);
    wait_out("t2b");
    chk("t2_midgrp_cfg_data", 64'(out_data), 64'h56789B);
    chk("t2_midgrp_count", 64'(out_count), 64'd2);
    tick();

    // 3: backpressure with two one-term groups
    out_ready = 1'b0;
    beat(40'd10, 1'b1, 1'b1);
    beat(40'd20, 1'b1, 1'b1);
    tick();
    chk("t3_held_valid", 64'(out_valid), 64'd1);
    chk("t3_held_data", 64'(out_data), 64'd10);
    chk("t3_in_ready_low", 64'(in_ready), 64'd0);
    tick(); tick();
    chk("t3_still_data", 64'(out_data), 64'd10);
    out_ready = 1'b1;
    tick();
    chk("t3_second_valid", 64'(out_valid), 64'd1);
    chk("t3_second_data", 64'(out_data), 64'd20);
    tick();
    chk("t3_drained", 64'(out_valid), 64'd0);

    // 4: overflow and count saturation
    cfg = MAC_QUAD;
    for (int i = 0; i < 300; i++) begin
      beat(40'hFF_FFFF_FFFF, (i == 0), (i == 299));
    end
    wait_out("t4");
    chk("t4_ovf", 64'(out_ovf), 64'd1);
    chk("t4_count", 64'(out_count), 64'd255);
    chk("t4_data", 64'(out_data), 64'h2BFF_FFFF_FED4);
    tick();

    // 5: first inside an open group restarts and flags; implicit start in IDLE
    cfg = MAC_SINGLE;
    beat(40'd4, 1'b1, 1'b0);
    beat(40'd9, 1'b1, 1'b1);
    wait_out("t5a");
    chk("t5_restart_data", 64'(out_data), 64'd9);
    chk("t5_restart_count", 64'(out_count), 64'd1);
    chk("t5_proto_err", 64'(proto_err), 64'd1);
    tick();
    beat(40'd2, 1'b0, 1'b0);
    beat(40'd6, 1'b0, 1'b1);
    wait_out("t5b");
    chk("t5_implicit_data", 64'(out_data), 64'd8);
    chk("t5_implicit_count", 64'(out_count), 64'd2);
    tick();

    // en=0 freezes: result held even with out_ready high, no accept
    out_ready = 1'b0;
    beat(40'd11, 1'b1, 1'b1);
    wait_out("en");
    en = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    chk("en0_valid_held", 64'(out_valid), 64'd1);
    chk("en0_data_held", 64'(out_data), 64'd11);
    chk("en0_in_ready", 64'(in_ready), 64'd0);
    en = 1'b1;
    tick();
    chk("en1_drain", 64'(out_valid), 64'd0);

    // 6: reset mid-group, then a fresh group starts from zero in IDLE
    beat(40'd100, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_data", 64'(out_data), 64'd0);
    chk("t6_rst_count", 64'(out_count), 64'd0);
    chk("t6_rst_ovf", 64'(out_ovf), 64'd0);
    chk("t6_rst_proto", 64'(proto_err), 64'd0);
    rst = 1'b0;
    beat(40'd2, 1'b0, 1'b0);
    beat(40'd3, 1'b0, 1'b1);
    wait_out("t6a");
    chk("t6_after_rst_data", 64'(out_data), 64'd5);
    chk("t6_after_rst_count", 64'(out_count), 64'd2);
    tick();

    // reset while a result is pending
    out_ready = 1'b0;
    beat(40'd50, 1'b1, 1'b1);
    wait_out("t6b");
    chk("t6_pending_data", 64'(out_data), 64'd50);
    rst = 1'b1;
    tick();
    chk("t6_pend_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_pend_rst_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
